restoring_div_ctrl: RTL and testbench
=====================================

RESTORING_DIV_CTRL -- requirements
Module: restoring_div_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a division; sampled only when busy=0.
REQ-005 dividend  input  WIDTH  unsigned dividend, captured on accepted start.
REQ-006 divisor  input  WIDTH  unsigned divisor, captured on accepted start.
REQ-007 busy  output  1  high while state=RUN.
REQ-008 done  output  1  one-cycle pulse, results valid.
REQ-009 quotient  output  WIDTH  registered quotient.
REQ-010 remainder  output  WIDTH  registered remainder.
REQ-011 div_by_zero  output  1  registered flag, valid with done.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 Start SHALL be accepted when state is IDLE or DONE and start=1; operands are captured at that edge, and the iteration counter is loaded with WIDTH.
REQ-014 Start SHALL be ignored while busy=1; captured operands are not disturbed.
REQ-015 Datapath: WIDTH+1-bit partial remainder R (cleared on accept), shift register holding dividend/quotient bits, and one internal WIDTH+1-bit subtractor computing R_shifted - {1'b0,divisor} with borrow-out.
REQ-016 Each RUN cycle: R_shifted = {R[WIDTH-1:0], next dividend MSB}; if borrow-out=0, R takes the difference and quotient bit=1; otherwise R=R_shifted and quotient bit=0; the counter decrements.
REQ-017 Exactly WIDTH RUN cycles SHALL execute; when the counter reaches 1, the next state is DONE.
REQ-018 Latency: start accepted at edge k -> busy=1 for edges k+1..k+WIDTH -> done=1 during cycle following edge k+WIDTH+1 (WIDTH+1 cycles after accept).
REQ-019 In DONE, quotient and remainder are updated and done=1 for exactly one cycle; DONE->IDLE unless a start is accepted (DONE->RUN, back-to-back).
REQ-020 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next DONE or reset; they SHALL NOT change during RUN.
REQ-021 Results: quotient = floor(dividend/divisor), remainder = dividend mod divisor (unsigned).
REQ-022 Divisor=0 (feature disabled): the full WIDTH iterations run and naturally yield quotient = all-ones and remainder = dividend.

Reset
REQ-023 rst=1 at any edge, including mid-RUN or in DONE, SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0; the in-flight operation is discarded.
REQ-024 rst SHALL take priority over a simultaneous start; the first start after rst deasserts is accepted normally.

Configuration
REQ-025 Macro DIV_BY_ZERO_DET_EN defined: an accepted start with divisor=0 SHALL go directly to DONE at the next edge (busy stays 0), with quotient = all-ones, remainder = dividend and div_by_zero=1.
REQ-026 Macro DIV_BY_ZERO_DET_EN undefined: there is no zero detection, div_by_zero is tied to 0, and divisor=0 follows REQ-022 timing and results.

Verification (WIDTH=8)
REQ-027 100/7 start -> busy for 8 cycles, done pulse 9 cycles after accept, quotient=14, remainder=2, div_by_zero=0.
REQ-028 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5; 200/200 -> quotient=1, remainder=0.
REQ-029 Start 50/0 -> with DIV_BY_ZERO_DET_EN: done 1 cycle after accept, quotient=0xFF, remainder=50, div_by_zero=1; without it: done after 9 cycles, same quotient/remainder, div_by_zero=0.
REQ-030 Start 100/7, then start 9/3 pulsed on RUN cycle 3 -> ignored, result 14/2; start 9/3 held during DONE -> accepted back-to-back, result 3/0 nine cycles later.
REQ-031 Start 100/7, rst on RUN cycle 4 -> next cycle all outputs 0 and no done pulse; then start 81/9 -> quotient=9, remainder=0.

Source files
------------

// File: rtl/restoring_div_ctrl.sv
// Restoring unsigned divider: IDLE/RUN/DONE controller with a one-bit-per-cycle datapath.
// Optional DIV_BY_ZERO_DET_EN short-circuits divisor==0 straight to DONE and raises div_by_zero.
module restoring_div_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem_acc;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic             accept;
  logic             zero_det;
  logic             dbz_pend;
  logic             unused_msb;

  assign accept     = start && (state != RUN);
  assign busy       = (state == RUN);
  assign r_shift    = {rem_acc[WIDTH-1:0], shreg[WIDTH-1]};
  assign diff       = {1'b0, r_shift} - {2'b00, dsr};
  assign borrow     = diff[WIDTH+1];
  // The partial remainder never exceeds WIDTH bits once stored; its MSB is scratch only.
  assign unused_msb = rem_acc[WIDTH];

`ifdef DIV_BY_ZERO_DET_EN
  assign zero_det = (divisor == '0);
`else
  assign zero_det = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = zero_det ? DONE : RUN;
      end
      RUN: begin
        if (count == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (accept) state_nxt = zero_det ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      rem_acc     <= '0;
      shreg       <= '0;
      dsr         <= '0;
      dbz_pend    <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        quotient    <= shreg;
        remainder   <= rem_acc[WIDTH-1:0];
        div_by_zero <= dbz_pend;
      end
      if (accept) begin
        dsr <= divisor;
        if (zero_det) begin
          // Preload the result the full iteration would have produced.
          count    <= '0;
          shreg    <= '1;
          rem_acc  <= {1'b0, dividend};
          dbz_pend <= 1'b1;
        end else begin
          count    <= CW'(WIDTH);
          shreg    <= dividend;
          rem_acc  <= '0;
          dbz_pend <= 1'b0;
        end
      end else if (state == RUN) begin
        shreg   <= {shreg[WIDTH-2:0], ~borrow};
        rem_acc <= borrow ? r_shift : diff[WIDTH:0];
        count   <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Bench for restoring_div_ctrl: directed cases with literal expectations plus random
// traffic checked every cycle against a phase-counting arithmetic model.
module tb_restoring_div_ctrl;
  localparam int W = 8;
`ifdef DIV_BY_ZERO_DET_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int chk = 0;
  int err = 0;

  // model state: ph = cycles since accept (W means controller sits in DONE), -1 = idle
  int           ph = -1;
  logic [W-1:0] pq = '0, pr = '0;
  logic         pdbz = 1'b0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0;

  restoring_div_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : model_compare
    forever begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("quotient", 32'(quotient), 32'(m_q));
      check("remainder", 32'(remainder), 32'(m_r));
      check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
      if (rst) begin
        ph = -1; m_done = 1'b0; m_q = '0; m_r = '0; m_dbz = 1'b0;
      end else begin
        m_done = (ph == W);
        if (ph == W) begin
          m_q = pq; m_r = pr; m_dbz = pdbz;
        end
        if (start && !(ph >= 0 && ph < W)) begin
          pq   = (divisor == 0) ? '1 : dividend / divisor;
          pr   = (divisor == 0) ? dividend : dividend % divisor;
          pdbz = DBZ_EN && (divisor == 0);
          ph   = pdbz ? W : 0;
        end else if (ph >= 0 && ph < W) begin
          ph++;
        end else begin
          ph = -1;
        end
      end
      m_busy = (ph >= 0 && ph < W);
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #2;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = int'(busy);
    forever begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      nbusy += int'(busy);
      if (n > 40) begin
        chk++; err++;
        $display("FAIL done_timeout waited=%0d cycles expected done within %0d", n, W + 1);
        break;
      end
    end
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    int n, nb;
    bit short_path;
    short_path = DBZ_EN && (b == 0);
    issue(a, b);
    wait_done(n, nb);
    check("latency", 32'(n), short_path ? 32'd1 : 32'(W + 1));
    check("busy_cycles", 32'(nb), short_path ? 32'd0 : 32'(W));
    check("lit_quotient", 32'(quotient), 32'(eq));
    check("lit_remainder", 32'(remainder), 32'(er));
    check("lit_dbz", 32'(div_by_zero), 32'(ez));
  endtask

  initial begin : stimulus
    int n, nb;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    directed(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    directed(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    directed(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    directed(8'd200, 8'd200, 8'd1, 8'd0, 1'b0);
    directed(8'd50, 8'd0, 8'hFF, 8'd50, DBZ_EN);

    // start pulse mid-RUN is ignored; start held in DONE is taken back-to-back
    issue(8'd100, 8'd7);
    repeat (2) @(posedge clk);
    #2 start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(posedge clk); #2 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #1;
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_q", 32'(quotient), 32'd14);
    check("b2b_first_r", 32'(remainder), 32'd2);
    #1 start = 1'b0;
    wait_done(n, nb);
    check("b2b_latency", 32'(n), 32'(W + 1));
    check("b2b_second_q", 32'(quotient), 32'd3);
    check("b2b_second_r", 32'(remainder), 32'd0);

    // reset during RUN discards the operation
    issue(8'd100, 8'd7);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("rst_no_done", 32'(done), 32'd0);
    end
    directed(8'd81, 8'd9, 8'd9, 8'd0, 1'b0);

    // random traffic, including starts while busy, zero divisors and stray resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      rst      = ($urandom_range(0, 99) == 0);
      start    = ($urandom_range(0, 2) == 0);
      dividend = W'($urandom);
      case ($urandom_range(0, 7))
        0:       divisor = '0;
        1, 2:    divisor = W'($urandom_range(1, 15));
        default: divisor = W'($urandom);
      endcase
    end
    @(posedge clk); #2;
    start = 1'b0; rst = 1'b0;
    repeat (W + 4) @(posedge clk);
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
